// File: rtl/shift_serializer_if.sv
// Handshake and serial-output bundle for shift_serializer.
// The master side feeds words in; the slave side is the serializer itself.
interface shift_serializer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  msb_first;
    logic                  abort;
    logic                  ser_out;
    logic                  ser_en;
    logic                  busy;
    logic                  frame_done;

    modport master (
        output in_data, in_valid, msb_first, abort,
        input  in_ready, ser_out, ser_en, busy, frame_done
    );

    modport slave (
        input  in_data, in_valid, msb_first, abort,
        output in_ready, ser_out, ser_en, busy, frame_done
    );
endinterface

// File: rtl/shift_serializer.sv
// Parallel-to-serial transmitter: takes one word over valid/ready and shifts it
// out LSB- or MSB-first, each bit held CLKS_PER_BIT cycles, with a shift strobe.
module shift_serializer #(
    parameter int DATA_WIDTH   = 16,
    parameter int HIGH         = DATA_WIDTH - 1,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    shift_serializer_if.slave  bus
);
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam int PER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  msb_q;
    logic [BIT_W-1:0]      bit_cnt;
    logic [PER_W-1:0]      per_cnt;
    logic                  period_end;
    logic                  last_bit;

    assign period_end = (state == SHIFT) && (per_cnt == PER_W'(CLKS_PER_BIT - 1));
    assign last_bit   = (bit_cnt == BIT_W'(DATA_WIDTH - 1));

    // Outputs decode registered state; only the strobes see abort directly.
    assign bus.in_ready   = (state == IDLE);
    assign bus.busy       = (state == SHIFT);
    assign bus.ser_out    = (state == SHIFT) && (msb_q ? shreg[HIGH] : shreg[0]);
    assign bus.ser_en     = period_end && !bus.abort;
    assign bus.frame_done = period_end && !bus.abort && last_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            msb_q   <= 1'b0;
            bit_cnt <= '0;
            per_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        shreg   <= bus.in_data;
                        msb_q   <= bus.msb_first;
                        bit_cnt <= '0;
                        per_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.abort) begin
                        bit_cnt <= '0;
                        per_cnt <= '0;
                        state   <= IDLE;
                    end else if (period_end) begin
                        per_cnt <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        shreg   <= msb_q ? (shreg << 1) : (shreg >> 1);
                        if (last_bit) begin
                            state <= IDLE;
                        end
                    end else begin
                        per_cnt <= per_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_serializer.sv
// Bench for shift_serializer: two instances (1 and 3 clocks per bit) share stimulus
// and are each checked every cycle against a frame-position model.
module tb_shift_serializer;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          msb_first = 1'b0;
    logic          abort = 1'b0;
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rev(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = v[DW-1-i];
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int CPB = (g == 0) ? 1 : 3;

        shift_serializer_if #(.DATA_WIDTH(DW)) bus ();
        assign bus.in_data   = in_data;
        assign bus.in_valid  = in_valid;
        assign bus.msb_first = msb_first;
        assign bus.abort     = abort;

        shift_serializer #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        // Model: a frame is just a word, an order and a cycle position t.
        bit            m_act = 0;
        int            m_t = 0;
        logic [DW-1:0] m_word = '0;
        bit            m_msb = 0;

        // Downstream observer: rebuilds words from the ser_en strobes.
        logic [DW-1:0] emit = '0;
        logic [DW-1:0] last_word = '0;
        logic [DW-1:0] prev_word = '0;
        bit            obs_msb = 0;
        int            en_cnt = 0, done_cnt = 0, acc_cnt = 0;
        int            acc_last = 0, acc_prev = 0, done_last = 0;
        int            busy_len = 0, last_len = 0;

        always @(negedge clk) begin : cmp
            logic e_out, e_en, e_done;
            int   bi;
            if (!rst_n) begin
                m_act = 0;
                m_t   = 0;
                chk($sformatf("l%0d rst ser_out", g), bus.ser_out, 0);
                chk($sformatf("l%0d rst ser_en", g), bus.ser_en, 0);
                chk($sformatf("l%0d rst busy", g), bus.busy, 0);
                chk($sformatf("l%0d rst frame_done", g), bus.frame_done, 0);
                chk($sformatf("l%0d rst in_ready", g), bus.in_ready, 1);
                en_cnt = 0;
                emit   = '0;
            end else begin
                e_out = 1'b0; e_en = 1'b0; e_done = 1'b0; bi = 0;
                if (m_act) begin
                    bi     = m_t / CPB;
                    e_out  = m_word[m_msb ? (DW - 1 - bi) : bi];
                    e_en   = ((m_t % CPB) == CPB - 1) && !abort;
                    e_done = e_en && (bi == DW - 1);
                end
                chk($sformatf("l%0d ser_out", g), bus.ser_out, e_out);
                chk($sformatf("l%0d ser_en", g), bus.ser_en, e_en);
                chk($sformatf("l%0d frame_done", g), bus.frame_done, e_done);
                chk($sformatf("l%0d busy", g), bus.busy, m_act);
                chk($sformatf("l%0d in_ready", g), bus.in_ready, !m_act);

                if (bus.busy) busy_len++;
                if (bus.ser_en) begin
                    emit = {emit[DW-2:0], bus.ser_out};
                    en_cnt++;
                end
                if (bus.frame_done) begin
                    done_cnt++;
                    done_last = cyc;
                    prev_word = last_word;
                    last_word = obs_msb ? emit : rev(emit);
                    last_len  = busy_len;
                end
                if (bus.in_ready && in_valid) begin
                    acc_cnt++;
                    acc_prev = acc_last;
                    acc_last = cyc;
                    obs_msb  = msb_first;
                    emit     = '0;
                    en_cnt   = 0;
                    busy_len = 0;
                end

                if (!m_act) begin
                    if (in_valid) begin
                        m_act  = 1;
                        m_t    = 0;
                        m_word = in_data;
                        m_msb  = msb_first;
                    end
                end else if (abort || m_t == DW * CPB - 1) begin
                    m_act = 0;
                end else begin
                    m_t++;
                end
            end
        end
    end

    task automatic wait_idle(input string tag);
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            if (lane[0].bus.in_ready && lane[1].bus.in_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk({tag, " idle reached"}, ok, 1);
    endtask

    task automatic wait_en(input int target, input string tag);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (lane[0].en_cnt == target) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk({tag, " strobe count reached"}, ok, 1);
    endtask

    task automatic send(input logic [DW-1:0] w, input logic m);
        in_data   = w;
        msb_first = m;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
    endtask

    initial begin : stim
        int base;
        logic [DW-1:0] w;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle with no valid: nothing may start.
        repeat (5) @(posedge clk);
        #1;
        chk("idle no accept", lane[0].acc_cnt, 0);
        chk("idle no strobe", lane[1].en_cnt, 0);

        // LSB first.
        send(16'hA5C3, 1'b0);
        wait_idle("lsb");
        chk("lsb l0 bit order", lane[0].emit, 16'hC3A5);
        chk("lsb l0 word", lane[0].last_word, 16'hA5C3);
        chk("lsb l0 strobes", lane[0].en_cnt, 16);
        chk("lsb l0 frame len", lane[0].last_len, 16);
        chk("lsb l1 word", lane[1].last_word, 16'hA5C3);
        chk("lsb l1 frame len", lane[1].last_len, 48);

        // MSB first.
        send(16'hA5C3, 1'b1);
        wait_idle("msb");
        chk("msb l1 bit order", lane[1].emit, 16'hA5C3);
        chk("msb l1 strobes", lane[1].en_cnt, 16);
        chk("msb l1 frame len", lane[1].last_len, 48);
        chk("msb l0 bit order", lane[0].emit, 16'hA5C3);

        // Back-to-back with valid held high.
        base      = lane[0].acc_cnt;
        in_data   = 16'h0001;
        msb_first = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_data = 16'h8000;
        for (int i = 0; i < 60; i++) begin
            if (lane[0].acc_cnt == base + 2) break;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("b2b accepted twice", lane[0].acc_cnt, base + 2);
        chk("b2b accept spacing", lane[0].acc_last - lane[0].acc_prev, 17);
        chk("b2b done to accept", lane[0].acc_last - lane[0].done_last, 1);
        wait_idle("b2b");
        chk("b2b first word", lane[0].prev_word, 16'h0001);
        chk("b2b second word", lane[0].last_word, 16'h8000);

        // Abort after the fifth strobe.
        base = lane[0].done_cnt;
        send(16'h3C5A, 1'($urandom_range(0, 1)));
        wait_en(5, "abort");
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort strobes", lane[0].en_cnt, 5);
        chk("abort no done", lane[0].done_cnt, base);
        chk("abort l0 idle", lane[0].bus.in_ready, 1);
        chk("abort l1 idle", lane[1].bus.in_ready, 1);
        send(16'hFFFF, 1'($urandom_range(0, 1)));
        wait_idle("after abort");
        chk("after abort l0 word", lane[0].last_word, 16'hFFFF);
        chk("after abort l0 strobes", lane[0].en_cnt, 16);
        chk("after abort l1 word", lane[1].last_word, 16'hFFFF);

        // Reset mid-frame, between clock edges.
        send(DW'($urandom), 1'($urandom_range(0, 1)));
        wait_en(8, "midreset");
        #2 rst_n = 1'b0;
        #1;
        for (int l = 0; l < 2; l++) begin
            chk("async rst busy", (l == 0) ? lane[0].bus.busy : lane[1].bus.busy, 0);
            chk("async rst in_ready", (l == 0) ? lane[0].bus.in_ready : lane[1].bus.in_ready, 1);
            chk("async rst ser_out", (l == 0) ? lane[0].bus.ser_out : lane[1].bus.ser_out, 0);
            chk("async rst ser_en", (l == 0) ? lane[0].bus.ser_en : lane[1].bus.ser_en, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        w = DW'($urandom);
        send(w, 1'b0);
        wait_idle("post reset");
        chk("post reset l0 word", lane[0].last_word, w);
        chk("post reset l1 word", lane[1].last_word, w);
        chk("post reset l0 strobes", lane[0].en_cnt, 16);

        // Randomized traffic, aborts included.
        base = lane[0].done_cnt;
        repeat (1500) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = DW'($urandom);
            msb_first = 1'($urandom_range(0, 1));
            abort     = ($urandom_range(0, 29) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        abort    = 1'b0;
        wait_idle("random");
        chk("random frames completed", lane[0].done_cnt > base + 20, 1);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "bench did not finish in time");
    end
endmodule
